branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Bimodal branch history table (BHT) of 2-bit saturating counters.
- Fetch queries it with the fetch PC; the prediction returns one cycle later.
- Execute updates it with the resolved outcome (taken_o of the branch condition generator) and the prediction that was used.
- The block detects mispredicts and issues a registered redirect PC to fetch.

Parameters:
- ENTRIES, 64, number of BHT entries; power of 2, >= 4. INDEX_BITS = $clog2(ENTRIES) is a derived localparam.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- ready_o  output  1  high once table initialisation is complete
- pred_valid_i  input  1  prediction request this cycle
- pred_pc_i  input  32  PC of the fetched instruction
- pred_valid_o  output  1  prediction result valid (1 cycle after request)
- pred_taken_o  output  1  predicted direction (counter MSB)
- flush_i  input  1  kill the in-flight prediction result
- update_valid_i  input  1  a conditional branch resolved this cycle
- update_pc_i  input  32  PC of the resolved branch
- update_taken_i  input  1  actual direction (from the branch condition generator)
- update_pred_i  input  1  direction that was predicted for this branch
- update_target_i  input  32  branch target address
- mispredict_o  output  1  one-cycle pulse: the previous update mispredicted
- redirect_pc_o  output  32  correct next PC, valid while mispredict_o is high

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: ready_o=0, pred_valid_o=0, pred_taken_o=0, mispredict_o=0, redirect_pc_o=0. The FSM enters INIT with init index 0.
- Table index: pc[INDEX_BITS+1:2].
- FSM INIT:
  - Writes WEAK_NT (2'b01) to one entry per cycle, index 0..ENTRIES-1.
  - Moves to RUN after the last entry (ENTRIES cycles).
  - ready_o=0. Predict requests and updates are ignored: pred_valid_o stays 0, no mispredict.
- FSM RUN: ready_o=1. Leaves RUN only on rst_i. Reset asserted mid-INIT restarts from index 0.
- Predict path:
  - Request at cycle N gives pred_valid_o=1 and pred_taken_o=table[idx][1] at N+1.
  - With no request, pred_valid_o=0 and pred_taken_o holds its last value.
  - flush_i at cycle N forces pred_valid_o=0 at N+1, even if a request was made at N.
- Update path (RUN, update_valid_i=1):
  - Counter saturates: taken increments to max 2'b11; not-taken decrements to min 2'b00.
  - Write takes effect at the next edge.
- Read/write collision: a predict and an update to the same index in the same cycle returns the pre-update counter value (read-before-write).
- Mispredict detection:
  - If update_valid_i and update_taken_i != update_pred_i at cycle N, then at N+1: mispredict_o=1 and redirect_pc_o = taken ? update_target_i : update_pc_i+4. The addition is 32-bit and wraps.
  - Otherwise mispredict_o=0 at N+1.
  - flush_i does not suppress mispredict_o.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, the block adds:
  - output branch_count_o [31:0]: count of accepted updates.
  - output mispredict_count_o [31:0]: count of mispredicts.
- Both counters are zeroed by rst_i, increment in the cycle after the event, and wrap modulo 2^32.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package defs.svh:
  - bht_ctr_e: STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11.
  - bp_state_e: BP_INIT, BP_RUN.
  - constant BHT_RESET_CTR = WEAK_NT.
- Sub-module bht_sat_ctr: combinational 2-bit saturating next-state function (ctr_i, taken_i -> ctr_o). It is instanced on the update path.

Test Plan:
- Reset then idle with ENTRIES=64 -> ready_o=0 for 64 cycles, 1 at cycle 65. Predict requests during INIT -> pred_valid_o stays 0.
- Predict PC 0x100 after init -> next cycle pred_valid_o=1, pred_taken_o=0 (WEAK_NT).
- Two updates PC 0x100, taken=1, pred=0 -> first gives mispredict_o=1, redirect_pc_o=target 0x200. A following predict of 0x100 returns taken=1. Three not-taken updates then return 0; two further not-taken updates keep the counter at 00, and one taken update still predicts 0.
- Update PC 0x7C, taken=0, pred=1 -> mispredict_o=1, redirect_pc_o=0x80. Update PC 0xFFFFFFFC not-taken mispredict -> redirect_pc_o=0x00000000.
- Same-cycle predict and update to index of 0x40 (counter 01, update taken) -> pred_taken_o=0 returned. The next predict returns 1.
- Predict with flush_i in the same cycle -> pred_valid_o=0. rst_i mid-RUN -> all outputs zero, INIT repeats, and trained entries read back WEAK_NT. With BRANCH_STATS_EN: 5 updates with 2 mispredicts -> branch_count_o=5, mispredict_count_o=2.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared BHT counter encodings, FSM states and reset counter value
package branch_predictor_pkg;
   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } bht_ctr_e;
   typedef enum logic {
      BP_INIT,
      BP_RUN
   } bp_state_e;
   localparam bht_ctr_e BHT_RESET_CTR = WEAK_NT;
endpackage

// File: rtl/branch_predictor_bht_sat_ctr.sv
// bht_sat_ctr: combinational 2-bit saturating counter next-state function
module bht_sat_ctr
   import branch_predictor_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] ctr_o
);
   // Step toward the resolved direction, holding at either end
   always_comb begin
      ctr_o = taken_i ? ((ctr_i == STRONG_T) ? ctr_i : ctr_i + 2'd1)
                      : ((ctr_i == STRONG_NT) ? ctr_i : ctr_i - 2'd1);
   end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal 2-bit BHT with mispredict redirect; BRANCH_STATS_EN adds update/mispredict counters
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        ready_o,
   input  logic        pred_valid_i,
   input  logic [31:0] pred_pc_i,
   output logic        pred_valid_o,
   output logic        pred_taken_o,
   input  logic        flush_i,
   input  logic        update_valid_i,
   input  logic [31:0] update_pc_i,
   input  logic        update_taken_i,
   input  logic        update_pred_i,
   input  logic [31:0] update_target_i,
`ifdef BRANCH_STATS_EN
   output logic [31:0] branch_count_o,
   output logic [31:0] mispredict_count_o,
`endif
   output logic        mispredict_o,
   output logic [31:0] redirect_pc_o
);
   localparam int INDEX_BITS = $clog2(ENTRIES);
   bp_state_e             state_q;
   logic [INDEX_BITS-1:0] init_idx_q;
   logic [1:0]            bht_q [ENTRIES];
   logic                  ready_q, pred_valid_q, pred_taken_q, mispredict_q;
   logic [31:0]           redirect_q;
   logic [INDEX_BITS-1:0] pred_idx, upd_idx;
   logic [1:0]            upd_ctr;
   logic                  run, pred_fire, mispredict_d;
   logic [31:0]           redirect_d;
   logic                  unused_pc;
   assign run       = state_q == BP_RUN;
   assign pred_idx  = pred_pc_i[INDEX_BITS+1:2];
   assign upd_idx   = update_pc_i[INDEX_BITS+1:2];
   assign pred_fire = run & pred_valid_i & ~flush_i;
   assign unused_pc = ^{pred_pc_i[31:INDEX_BITS+2], pred_pc_i[1:0]};
   bht_sat_ctr u_sat (
      .ctr_i   (bht_q[upd_idx]),
      .taken_i (update_taken_i),
      .ctr_o   (upd_ctr)
   );
   // Mispredict when the resolved direction differs from the one used; redirect to the correct path
   always_comb begin
      mispredict_d = run & update_valid_i & (update_taken_i != update_pred_i);
      redirect_d   = update_taken_i ? update_target_i : update_pc_i + 32'd4;
   end
   // Init sequencer: sweep one entry per cycle, then run until reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= BP_INIT;
         init_idx_q <= '0;
         ready_q    <= 1'b0;
      end else if (state_q == BP_INIT) begin
         init_idx_q <= init_idx_q + INDEX_BITS'(1);
         if (init_idx_q == INDEX_BITS'(ENTRIES - 1)) begin
            state_q <= BP_RUN;
            ready_q <= 1'b1;
         end
      end
   end
   // Table write: reset value during the init sweep, saturating update once running
   always_ff @(posedge clk_i) begin
      if (!run) bht_q[init_idx_q] <= BHT_RESET_CTR;
      else if (update_valid_i) bht_q[upd_idx] <= upd_ctr;
   end
   // Registered prediction and redirect outputs; table read sees the pre-update counter
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         mispredict_q <= 1'b0;
         redirect_q   <= '0;
      end else begin
         pred_valid_q <= pred_fire;
         if (pred_fire) pred_taken_q <= bht_q[pred_idx][1];
         mispredict_q <= mispredict_d;
         if (mispredict_d) redirect_q <= redirect_d;
      end
   end
`ifdef BRANCH_STATS_EN
   logic [31:0] branch_count_q, mispredict_count_q;
   // Wrapping event counters for accepted updates and mispredicts
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         if (run & update_valid_i) branch_count_q <= branch_count_q + 32'd1;
         if (mispredict_d) mispredict_count_q <= mispredict_count_q + 32'd1;
      end
   end
   assign branch_count_o     = branch_count_q;
   assign mispredict_count_o = mispredict_count_q;
`endif
   assign ready_o       = ready_q;
   assign pred_valid_o  = pred_valid_q;
   assign pred_taken_o  = pred_taken_q;
   assign mispredict_o  = mispredict_q;
   assign redirect_pc_o = redirect_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench for branch_predictor with directed vectors
module tb_branch_predictor;
   logic        clk = 1'b0, rst_i, ready_o, pred_valid_i, pred_valid_o, pred_taken_o, flush_i;
   logic [31:0] pred_pc_i, update_pc_i, update_target_i, redirect_pc_o;
   logic        update_valid_i, update_taken_i, update_pred_i, mispredict_o;
`ifdef BRANCH_STATS_EN
   logic [31:0] branch_count_o, mispredict_count_o;
`endif
   int          checks = 0, fails = 0;
   bit          live = 0;
   logic        pq [$];
   logic [31:0] mq [$];
   branch_predictor #(.ENTRIES(64)) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .ready_o         (ready_o),
      .pred_valid_i    (pred_valid_i),
      .pred_pc_i       (pred_pc_i),
      .pred_valid_o    (pred_valid_o),
      .pred_taken_o    (pred_taken_o),
      .flush_i         (flush_i),
      .update_valid_i  (update_valid_i),
      .update_pc_i     (update_pc_i),
      .update_taken_i  (update_taken_i),
      .update_pred_i   (update_pred_i),
      .update_target_i (update_target_i),
`ifdef BRANCH_STATS_EN
      .branch_count_o     (branch_count_o),
      .mispredict_count_o (mispredict_count_o),
`endif
      .mispredict_o    (mispredict_o),
      .redirect_pc_o   (redirect_pc_o)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic predict(input logic [31:0] pc, input logic e);
      pred_valid_i = 1'b1;
      pred_pc_i    = pc;
      if (live && !flush_i) pq.push_back(e);
      step();
      pred_valid_i = 1'b0;
   endtask
   task automatic update(input logic [31:0] pc, input logic t, input logic p, input logic [31:0] tgt);
      update_valid_i  = 1'b1;
      update_pc_i     = pc;
      update_taken_i  = t;
      update_pred_i   = p;
      update_target_i = tgt;
      if (live && t != p) mq.push_back(t ? tgt : pc + 32'd4);
      step();
      update_valid_i = 1'b0;
   endtask
   task automatic init_sweep();
      for (int i = 1; i <= 64; i++) begin
         if (i == 10) begin
            pred_valid_i = 1'b1;
            pred_pc_i    = 32'h100;
         end
         if (i == 20) begin
            update_valid_i = 1'b1;
            update_pc_i    = 32'h100;
            update_taken_i = 1'b1;
            update_pred_i  = 1'b0;
         end
         step();
         pred_valid_i   = 1'b0;
         update_valid_i = 1'b0;
         if (i == 63) chk("ready_during_init", {31'd0, ready_o}, 32'd0);
      end
      chk("ready_after_init", {31'd0, ready_o}, 32'd1);
      live = 1;
   endtask
   task automatic chk_reset();
      chk("rst_ready", {31'd0, ready_o}, 32'd0);
      chk("rst_pred_valid", {31'd0, pred_valid_o}, 32'd0);
      chk("rst_pred_taken", {31'd0, pred_taken_o}, 32'd0);
      chk("rst_mispredict", {31'd0, mispredict_o}, 32'd0);
      chk("rst_redirect", redirect_pc_o, 32'd0);
   endtask
   // Monitor: pop and compare whenever the DUT presents a prediction or a mispredict
   always @(negedge clk) begin
      if (pred_valid_o) begin
         if (pq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL pred_unexpected: got pred_valid_o=1 taken=%b, expected no prediction", pred_taken_o);
         end else chk("pred_taken", {31'd0, pred_taken_o}, {31'd0, pq.pop_front()});
      end
      if (mispredict_o) begin
         if (mq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL mispredict_unexpected: got mispredict_o=1 redirect=%h, expected no mispredict", redirect_pc_o);
         end else chk("redirect_pc", redirect_pc_o, mq.pop_front());
      end
   end
   initial begin
      rst_i = 1'b1; pred_valid_i = 1'b0; pred_pc_i = '0; flush_i = 1'b0;
      update_valid_i = 1'b0; update_pc_i = '0; update_taken_i = 1'b0;
      update_pred_i = 1'b0; update_target_i = '0;
      step();
      step();
      chk_reset();
      rst_i = 1'b0;
      init_sweep();
      predict(32'h100, 1'b0);
      update(32'h100, 1'b1, 1'b0, 32'h200);
      update(32'h100, 1'b1, 1'b0, 32'h200);
      predict(32'h100, 1'b1);
      repeat (3) update(32'h100, 1'b0, 1'b0, 32'h200);
      predict(32'h100, 1'b0);
      repeat (2) update(32'h100, 1'b0, 1'b0, 32'h200);
      update(32'h100, 1'b1, 1'b1, 32'h200);
      predict(32'h100, 1'b0);
      update(32'h7C, 1'b0, 1'b1, 32'h1000);
      update(32'hFFFFFFFC, 1'b0, 1'b1, 32'h1000);
      predict(32'h7C, 1'b0);
      pred_valid_i = 1'b1;
      pred_pc_i    = 32'h40;
      pq.push_back(1'b0);
      update(32'h40, 1'b1, 1'b1, 32'h500);
      pred_valid_i = 1'b0;
      predict(32'h40, 1'b1);
      flush_i = 1'b1;
      predict(32'h40, 1'b1);
      update(32'h40, 1'b0, 1'b1, 32'h500);
      flush_i = 1'b0;
      predict(32'h40, 1'b0);
      update(32'h100, 1'b1, 1'b1, 32'h200);
      update(32'h100, 1'b1, 1'b1, 32'h200);
      predict(32'h100, 1'b1);
      update(32'h100, 1'b0, 1'b1, 32'h300);
      rst_i = 1'b1;
      live  = 0;
      step();
      chk_reset();
      rst_i = 1'b0;
      repeat (10) step();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      init_sweep();
      predict(32'h100, 1'b0);
      predict(32'h40, 1'b0);
      update(32'h208, 1'b1, 1'b0, 32'h400);
      update(32'h208, 1'b1, 1'b1, 32'h400);
      update(32'h208, 1'b0, 1'b0, 32'h400);
      update(32'h208, 1'b0, 1'b1, 32'h400);
      update(32'h208, 1'b1, 1'b1, 32'h400);
      predict(32'h208, 1'b1);
`ifdef BRANCH_STATS_EN
      chk("branch_count", branch_count_o, 32'd5);
      chk("mispredict_count", mispredict_count_o, 32'd2);
`endif
      step();
      step();
      chk("pred_queue_drained", pq.size(), 32'd0);
      chk("mispredict_queue_drained", mq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
